// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults and depth derivation for the fifo_modport FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default data width of fifo_in / fifo_out.
  localparam int DATA_WIDTH_DEF = 8;

  // Default width of the occupancy counter. Pointers are one bit narrower,
  // so the counter can represent 0..DEPTH inclusive.
  localparam int FIFO_WIDTH_DEF = 5;

  // Storage depth implied by a given counter width.
  function automatic int depth_of(input int fifo_width);
    return 2 ** (fifo_width - 1);
  endfunction

  // Depth at the default counter width (16 entries).
  localparam int DEPTH_DEF = depth_of(FIFO_WIDTH_DEF);

  // Almost-empty / almost-full threshold defaults.
  localparam int P_EMPTY_TH_DEF = 2;
  localparam int P_FULL_TH_DEF  = DEPTH_DEF - 2;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Purpose  : DEPTH x DATA_WIDTH register array, synchronous write port and
//            registered read port. Array contents are never reset; only the
//            read register clears.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,      // asynchronous, active-low
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word; hold it when no read is accepted.
  // A write to the same address on the same edge returns the old contents,
  // which is what a simultaneous read/write at full requires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_modport.sv
`default_nettype none
// ============================================================================
// Module   : fifo_modport
// Purpose  : Single-clock synchronous FIFO with registered read data,
//            occupancy counter, full/empty, almost-full/almost-empty and
//            registered overflow/underflow pulses. Illegal requests are
//            dropped without touching stored data.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_modport
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int P_EMPTY_TH = P_EMPTY_TH_DEF,
  parameter int P_FULL_TH  = depth_of(FIFO_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  wr_enb,
  input  logic [DATA_WIDTH-1:0] fifo_in,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  empty,
  output logic                  full,
  output logic                  p_empty,
  output logic                  p_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [FIFO_WIDTH-1:0] f_counter
);

  localparam int DEPTH = depth_of(FIFO_WIDTH);
  localparam int PTR_W = FIFO_WIDTH - 1;

  // Width-matched constants for counter and pointer arithmetic/compares.
  localparam logic [FIFO_WIDTH-1:0] CNT_ONE   = FIFO_WIDTH'(1);
  localparam logic [FIFO_WIDTH-1:0] CNT_DEPTH = FIFO_WIDTH'(DEPTH);
  localparam logic [FIFO_WIDTH-1:0] CNT_E_TH  = FIFO_WIDTH'(P_EMPTY_TH);
  localparam logic [FIFO_WIDTH-1:0] CNT_F_TH  = FIFO_WIDTH'(P_FULL_TH);
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             wr_en_ok;
  logic             rd_en_ok;
  logic             wr_rejected;
  logic             rd_rejected;

  // Status flags are pure decodes of the registered occupancy count.
  always_comb begin
    empty   = (f_counter == '0);
    full    = (f_counter == CNT_DEPTH);
    p_empty = (f_counter <= CNT_E_TH);
    p_full  = (f_counter >= CNT_F_TH);
  end

  // Request qualification. A write at full is still legal when a read frees
  // a slot on the same edge; a read at empty is never legal, so data written
  // into an empty FIFO cannot fall straight through to fifo_out.
  always_comb begin
    wr_en_ok    = wr_enb & (~full | rd_enb);
    rd_en_ok    = rd_enb & ~empty;
    wr_rejected = wr_enb & full & ~rd_enb;
    rd_rejected = rd_enb & empty;
  end

  // Write pointer: advance on every accepted write, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
    end else if (wr_en_ok) begin
      wp <= wp + PTR_ONE;
    end
  end

  // Read pointer: advance on every accepted read, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp <= '0;
    end else if (rd_en_ok) begin
      rp <= rp + PTR_ONE;
    end
  end

  // Occupancy: +1 for write only, -1 for read only, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_counter <= '0;
    end else begin
      case ({wr_en_ok, rd_en_ok})
        2'b10:   f_counter <= f_counter + CNT_ONE;
        2'b01:   f_counter <= f_counter - CNT_ONE;
        default: f_counter <= f_counter;
      endcase
    end
  end

  // Error pulses: re-evaluated every edge, so a sustained illegal request
  // keeps the corresponding pulse high for as long as it persists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_rejected;
      underflow <= rd_rejected;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_ok),
    .wr_addr (wp),
    .wr_data (fifo_in),
    .rd_en   (rd_en_ok),
    .rd_addr (rp),
    .rd_data (fifo_out)
  );

endmodule : fifo_modport
`default_nettype wire

// File: tb/tb_fifo_modport.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_modport
// Purpose  : Self-checking bench for fifo_modport: directed fill/drain/corner
//            sequences plus randomized traffic, compared every cycle against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_modport;

  localparam int DW       = 8;
  localparam int FW       = 5;
  localparam int DEPTH    = 16;
  localparam int E_TH     = 2;
  localparam int F_TH     = DEPTH - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_enb = 1'b0;
  logic          rd_enb = 1'b0;
  logic [DW-1:0] fifo_in = '0;
  logic [DW-1:0] fifo_out;
  logic          empty;
  logic          full;
  logic          p_empty;
  logic          p_full;
  logic          overflow;
  logic          underflow;
  logic [FW-1:0] f_counter;

  fifo_modport #(
    .DATA_WIDTH (DW),
    .FIFO_WIDTH (FW),
    .P_EMPTY_TH (E_TH),
    .P_FULL_TH  (F_TH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_enb    (wr_enb),
    .fifo_in   (fifo_in),
    .rd_enb    (rd_enb),
    .fifo_out  (fifo_out),
    .empty     (empty),
    .full      (full),
    .p_empty   (p_empty),
    .p_full    (p_full),
    .overflow  (overflow),
    .underflow (underflow),
    .f_counter (f_counter)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as a queue plus the expected registers.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_out = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all();
    int n;
    n = q.size();
    check("f_counter", 32'(f_counter), 32'(n));
    check("empty",     32'(empty),     32'(n == 0));
    check("full",      32'(full),      32'(n == DEPTH));
    check("p_empty",   32'(p_empty),   32'(n <= E_TH));
    check("p_full",    32'(p_full),    32'(n >= F_TH));
    check("fifo_out",  32'(fifo_out),  32'(m_out));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock of stimulus; the model applies the FIFO rules afterwards.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wr_enb  = w;
    fifo_in = d;
    rd_enb  = r;
    @(posedge clk);
    #1;
    m_ovf = w && was_full && !r;
    m_unf = r && was_empty;
    if (r && !was_empty) m_out = q.pop_front();
    if (w && (!was_full || r)) q.push_back(d);
    wr_enb = 1'b0;
    rd_enb = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    int wpct;
    int rpct;
    int wpcts [6] = '{80, 20, 50, 95, 10, 50};
    int rpcts [6] = '{20, 80, 50, 90, 15, 60};

    // Power-on reset.
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b1;

    // Fill with 0x01..0x10; flags are tracked every cycle by check_all.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    // 17th write is rejected.
    step(1'b1, 8'hEE, 1'b0);
    check("ovf17", 32'(overflow), 32'd1);
    check("cnt17", 32'(f_counter), 32'd16);
    // Overflow pulse lasts one cycle.
    step(1'b0, 8'h00, 1'b0);

    // Drain 16 then an extra read.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_data", 32'(fifo_out), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1);
    check("unf17", 32'(underflow), 32'd1);
    check("hold17", 32'(fifo_out), 32'h10);
    step(1'b0, 8'h00, 1'b0);

    // Simultaneous read/write at full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    check("simfull_out", 32'(fifo_out), 32'h40);
    check("simfull_cnt", 32'(f_counter), 32'd16);
    check("simfull_ovf", 32'(overflow), 32'd0);
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1);

    // Simultaneous read/write at empty.
    step(1'b1, 8'hAA, 1'b1);
    check("simempty_unf", 32'(underflow), 32'd1);
    check("simempty_cnt", 32'(f_counter), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("simempty_rd", 32'(fifo_out), 32'hAA);

    // Wrap-around: 10 in/out, then 16 in/out.
    for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

    // Randomized traffic with varying read/write bias.
    for (int ph = 0; ph < 6; ph++) begin
      wpct = wpcts[ph];
      rpct = rpcts[ph];
      for (int i = 0; i < 300; i++) begin
        d = DW'($urandom);
        step($urandom_range(99) < wpct, d, $urandom_range(99) < rpct);
      end
    end

    // Asynchronous reset mid-traffic: make sure there is data queued first.
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
    rst = 1'b0;
    #2;
    check("rst_cnt",   32'(f_counter), 32'd0);
    check("rst_empty", 32'(empty),     32'd1);
    check("rst_pempt", 32'(p_empty),   32'd1);
    check("rst_out",   32'(fifo_out),  32'd0);
    check("rst_full",  32'(full),      32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    model_reset();
    #2;
    rst = 1'b1;

    // Traffic after reset release.
    for (int i = 0; i < 400; i++) begin
      d = DW'($urandom);
      step($urandom_range(99) < 55, d, $urandom_range(99) < 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_modport
`default_nettype wire
